// File: rtl/alu_ctrl_decoder.sv
// RV32I ID-stage decoder producing the EX-stage ALU control bundle.
// Decode is combinational from instr_i; results land in the ID/EX register with stall/flush/bubble.
module alu_ctrl_decoder #(
    parameter int unsigned XLEN           = 32,
    parameter logic [3:0]  ILLEGAL_ALU_OP = 4'h0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            valid_i,
    input  logic            stall_i,
    input  logic            flush_i,
    output logic [3:0]      alu_op_o,
    output logic [1:0]      op_a_sel_o,
    output logic            op_b_sel_o,
    output logic [XLEN-1:0] imm_o,
    output logic [4:0]      rs1_addr_o,
    output logic [4:0]      rs2_addr_o,
    output logic [4:0]      rd_addr_o,
    output logic            rd_we_o,
    output logic [XLEN-1:0] pc_o,
    output logic            valid_o,
    output logic            illegal_o
);

    localparam int unsigned REG_W = 5;

    localparam logic [3:0] ALU_ADD    = 4'h0;
    localparam logic [3:0] ALU_SUB    = 4'h1;
    localparam logic [3:0] ALU_SLT    = 4'h2;
    localparam logic [3:0] ALU_SLTU   = 4'h3;
    localparam logic [3:0] ALU_XOR    = 4'h4;
    localparam logic [3:0] ALU_OR     = 4'h5;
    localparam logic [3:0] ALU_AND    = 4'h6;
    localparam logic [3:0] ALU_SLL    = 4'h7;
    localparam logic [3:0] ALU_SRL    = 4'h8;
    localparam logic [3:0] ALU_SRA    = 4'h9;
    localparam logic [3:0] ALU_PASS_B = 4'hA;

    localparam logic [1:0] SEL_A_RS1 = 2'd0;
    localparam logic [1:0] SEL_A_PC  = 2'd1;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [REG_W-1:0] rd_raw;
    logic [XLEN-1:0]  imm_i_ext;
    logic [XLEN-1:0]  imm_s_ext;
    logic [XLEN-1:0]  imm_b_ext;
    logic [XLEN-1:0]  imm_u_ext;
    logic [XLEN-1:0]  imm_j_ext;
    logic [XLEN-1:0]  imm_shamt;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    assign rd_raw = instr_i[11:7];

    assign imm_i_ext = XLEN'($signed(instr_i[31:20]));
    assign imm_s_ext = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
    assign imm_b_ext = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0}));
    assign imm_u_ext = XLEN'($signed({instr_i[31:12], 12'b0}));
    assign imm_j_ext = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0}));
    assign imm_shamt = XLEN'(instr_i[24:20]);

    logic [3:0]      dec_alu_op_c;
    logic [1:0]      dec_a_sel_c;
    logic            dec_b_sel_c;
    logic [XLEN-1:0] dec_imm_c;
    logic            dec_we_c;
    logic            dec_illegal_c;

    // Opcode/funct decode; illegal encodings collapse to a neutral, non-writing op at the end
    always_comb begin
        dec_alu_op_c  = ALU_ADD;
        dec_a_sel_c   = SEL_A_RS1;
        dec_b_sel_c   = 1'b0;
        dec_imm_c     = '0;
        dec_we_c      = 1'b0;
        dec_illegal_c = 1'b0;

        if (instr_i[1:0] != 2'b11) begin
            dec_illegal_c = 1'b1;
        end else begin
            case (opcode)
                OPC_OP: begin
                    dec_we_c = 1'b1;
                    case (funct3)
                        3'b000: begin
                            if (funct7 == F7_BASE)     dec_alu_op_c = ALU_ADD;
                            else if (funct7 == F7_ALT) dec_alu_op_c = ALU_SUB;
                            else                       dec_illegal_c = 1'b1;
                        end
                        3'b101: begin
                            if (funct7 == F7_BASE)     dec_alu_op_c = ALU_SRL;
                            else if (funct7 == F7_ALT) dec_alu_op_c = ALU_SRA;
                            else                       dec_illegal_c = 1'b1;
                        end
                        default: begin
                            if (funct7 != F7_BASE) dec_illegal_c = 1'b1;
                            case (funct3)
                                3'b001:  dec_alu_op_c = ALU_SLL;
                                3'b010:  dec_alu_op_c = ALU_SLT;
                                3'b011:  dec_alu_op_c = ALU_SLTU;
                                3'b100:  dec_alu_op_c = ALU_XOR;
                                3'b110:  dec_alu_op_c = ALU_OR;
                                default: dec_alu_op_c = ALU_AND;
                            endcase
                        end
                    endcase
                end
                OPC_OP_IMM: begin
                    dec_we_c    = 1'b1;
                    dec_b_sel_c = 1'b1;
                    dec_imm_c   = imm_i_ext;
                    case (funct3)
                        3'b000: dec_alu_op_c = ALU_ADD;
                        3'b010: dec_alu_op_c = ALU_SLT;
                        3'b011: dec_alu_op_c = ALU_SLTU;
                        3'b100: dec_alu_op_c = ALU_XOR;
                        3'b110: dec_alu_op_c = ALU_OR;
                        3'b111: dec_alu_op_c = ALU_AND;
                        3'b001: begin
                            dec_imm_c    = imm_shamt;
                            dec_alu_op_c = ALU_SLL;
                            if (funct7 != F7_BASE) dec_illegal_c = 1'b1;
                        end
                        default: begin
                            dec_imm_c = imm_shamt;
                            if (funct7 == F7_BASE)     dec_alu_op_c = ALU_SRL;
                            else if (funct7 == F7_ALT) dec_alu_op_c = ALU_SRA;
                            else                       dec_illegal_c = 1'b1;
                        end
                    endcase
                end
                OPC_LUI: begin
                    dec_alu_op_c = ALU_PASS_B;
                    dec_b_sel_c  = 1'b1;
                    dec_imm_c    = imm_u_ext;
                    dec_we_c     = 1'b1;
                end
                OPC_AUIPC: begin
                    dec_a_sel_c = SEL_A_PC;
                    dec_b_sel_c = 1'b1;
                    dec_imm_c   = imm_u_ext;
                    dec_we_c    = 1'b1;
                end
                OPC_LOAD, OPC_JALR: begin
                    dec_b_sel_c = 1'b1;
                    dec_imm_c   = imm_i_ext;
                    dec_we_c    = 1'b1;
                end
                OPC_STORE: begin
                    dec_b_sel_c = 1'b1;
                    dec_imm_c   = imm_s_ext;
                end
                OPC_BRANCH: begin
                    dec_a_sel_c = SEL_A_PC;
                    dec_b_sel_c = 1'b1;
                    dec_imm_c   = imm_b_ext;
                end
                OPC_JAL: begin
                    dec_a_sel_c = SEL_A_PC;
                    dec_b_sel_c = 1'b1;
                    dec_imm_c   = imm_j_ext;
                    dec_we_c    = 1'b1;
                end
                default: dec_illegal_c = 1'b1;
            endcase
        end

        if (dec_illegal_c) begin
            dec_alu_op_c = ILLEGAL_ALU_OP;
            dec_a_sel_c  = SEL_A_RS1;
            dec_b_sel_c  = 1'b0;
            dec_imm_c    = '0;
            dec_we_c     = 1'b0;
        end
        if (rd_raw == '0) dec_we_c = 1'b0;
    end

    // ID/EX register: flush beats stall; an empty slot is an all-zero bubble
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            alu_op_o   <= '0;
            op_a_sel_o <= '0;
            op_b_sel_o <= 1'b0;
            imm_o      <= '0;
            rs1_addr_o <= '0;
            rs2_addr_o <= '0;
            rd_addr_o  <= '0;
            rd_we_o    <= 1'b0;
            pc_o       <= '0;
            valid_o    <= 1'b0;
            illegal_o  <= 1'b0;
        end else if (flush_i || (!stall_i && !valid_i)) begin
            alu_op_o   <= '0;
            op_a_sel_o <= '0;
            op_b_sel_o <= 1'b0;
            imm_o      <= '0;
            rs1_addr_o <= '0;
            rs2_addr_o <= '0;
            rd_addr_o  <= '0;
            rd_we_o    <= 1'b0;
            pc_o       <= '0;
            valid_o    <= 1'b0;
            illegal_o  <= 1'b0;
        end else if (!stall_i) begin
            alu_op_o   <= dec_alu_op_c;
            op_a_sel_o <= dec_a_sel_c;
            op_b_sel_o <= dec_b_sel_c;
            imm_o      <= dec_imm_c;
            rs1_addr_o <= instr_i[19:15];
            rs2_addr_o <= instr_i[24:20];
            rd_addr_o  <= rd_raw;
            rd_we_o    <= dec_we_c;
            pc_o       <= pc_i;
            valid_o    <= 1'b1;
            illegal_o  <= dec_illegal_c;
        end
    end

endmodule

// File: tb/tb_alu_ctrl_decoder.sv
// Directed bench for alu_ctrl_decoder: per-feature tasks with hand-computed expectations.
module tb_alu_ctrl_decoder;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] instr_i;
    logic [31:0] pc_i;
    logic        valid_i;
    logic        stall_i;
    logic        flush_i;
    logic [3:0]  alu_op_o;
    logic [1:0]  op_a_sel_o;
    logic        op_b_sel_o;
    logic [31:0] imm_o;
    logic [4:0]  rs1_addr_o;
    logic [4:0]  rs2_addr_o;
    logic [4:0]  rd_addr_o;
    logic        rd_we_o;
    logic [31:0] pc_o;
    logic        valid_o;
    logic        illegal_o;

    int tests = 0;
    int fails = 0;

    // {alu_op, a_sel, b_sel, rd_we, valid, illegal}
    logic [9:0] ctrl;
    assign ctrl = {alu_op_o, op_a_sel_o, op_b_sel_o, rd_we_o, valid_o, illegal_o};

    alu_ctrl_decoder #(.XLEN(32), .ILLEGAL_ALU_OP(4'h0)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .instr_i    (instr_i),
        .pc_i       (pc_i),
        .valid_i    (valid_i),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .alu_op_o   (alu_op_o),
        .op_a_sel_o (op_a_sel_o),
        .op_b_sel_o (op_b_sel_o),
        .imm_o      (imm_o),
        .rs1_addr_o (rs1_addr_o),
        .rs2_addr_o (rs2_addr_o),
        .rd_addr_o  (rd_addr_o),
        .rd_we_o    (rd_we_o),
        .pc_o       (pc_o),
        .valid_o    (valid_o),
        .illegal_o  (illegal_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic apply(input logic [31:0] instr, input logic [31:0] pc, input logic vld);
        instr_i = instr;
        pc_i    = pc;
        valid_i = vld;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset;
        tests++;
        if ({ctrl, imm_o, pc_o, rs1_addr_o, rs2_addr_o, rd_addr_o} !== '0) begin
            fails++;
            $display("FAIL reset_state got ctrl=%h imm=%h pc=%h exp all zero", ctrl, imm_o, pc_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_op;
        apply(32'h002081B3, 32'h0000_0040, 1'b1);
        tests++;
        if (ctrl !== {4'h0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
            fails++; $display("FAIL add_ctrl got %h exp %h", ctrl, {4'h0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0});
        end
        tests++;
        if ({rs1_addr_o, rs2_addr_o, rd_addr_o, pc_o} !== {5'd1, 5'd2, 5'd3, 32'h40}) begin
            fails++; $display("FAIL add_fields got rs1=%0d rs2=%0d rd=%0d pc=%h exp 1 2 3 00000040",
                              rs1_addr_o, rs2_addr_o, rd_addr_o, pc_o);
        end
        apply(32'h402081B3, 32'h0, 1'b1);
        tests++;
        if (ctrl !== {4'h1, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
            fails++; $display("FAIL sub_ctrl got %h exp %h", ctrl, {4'h1, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0});
        end
        apply(32'h022081B3, 32'h0, 1'b1);
        tests++;
        if (ctrl !== {4'h0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
            fails++; $display("FAIL op_bad_funct7 got %h exp %h", ctrl, {4'h0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1});
        end
    endtask

    task automatic test_op_imm;
        apply(32'h40335293, 32'h0, 1'b1);
        tests++;
        if ({ctrl, imm_o, rs1_addr_o, rd_addr_o} !== {4'h9, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h3, 5'd6, 5'd5}) begin
            fails++; $display("FAIL srai got ctrl=%h imm=%h rs1=%0d rd=%0d exp ctrl=%h imm=3 rs1=6 rd=5",
                              ctrl, imm_o, rs1_addr_o, rd_addr_o, {4'h9, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0});
        end
        apply(32'h02335293, 32'h0, 1'b1);
        tests++;
        if ({ctrl, imm_o} !== {4'h0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0}) begin
            fails++; $display("FAIL srai_bad_funct7 got ctrl=%h imm=%h exp ctrl=%h imm=0",
                              ctrl, imm_o, {4'h0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1});
        end
        apply(32'h00100013, 32'h0, 1'b1);
        tests++;
        if ({ctrl, imm_o} !== {4'h0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1}) begin
            fails++; $display("FAIL addi_x0 got ctrl=%h imm=%h exp ctrl=%h imm=1",
                              ctrl, imm_o, {4'h0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0});
        end
    endtask

    task automatic test_upper_mem_ctrl;
        apply(32'h123450B7, 32'h0, 1'b1);
        tests++;
        if ({ctrl, imm_o} !== {4'hA, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h12345000}) begin
            fails++; $display("FAIL lui got ctrl=%h imm=%h exp ctrl=%h imm=12345000",
                              ctrl, imm_o, {4'hA, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0});
        end
        apply(32'h12345097, 32'h100, 1'b1);
        tests++;
        if ({ctrl, imm_o, pc_o} !== {4'h0, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h12345000, 32'h100}) begin
            fails++; $display("FAIL auipc got ctrl=%h imm=%h pc=%h exp ctrl=%h imm=12345000 pc=00000100",
                              ctrl, imm_o, pc_o, {4'h0, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0});
        end
        apply(32'hFE20AE23, 32'h0, 1'b1);
        tests++;
        if ({ctrl, imm_o} !== {4'h0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFC}) begin
            fails++; $display("FAIL sw got ctrl=%h imm=%h exp ctrl=%h imm=fffffffc",
                              ctrl, imm_o, {4'h0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0});
        end
        apply(32'h00208463, 32'h200, 1'b1);
        tests++;
        if ({ctrl, imm_o} !== {4'h0, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h8}) begin
            fails++; $display("FAIL beq got ctrl=%h imm=%h exp ctrl=%h imm=8",
                              ctrl, imm_o, {4'h0, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0});
        end
        apply(32'h010000EF, 32'h300, 1'b1);
        tests++;
        if ({ctrl, imm_o} !== {4'h0, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h10}) begin
            fails++; $display("FAIL jal got ctrl=%h imm=%h exp ctrl=%h imm=10",
                              ctrl, imm_o, {4'h0, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0});
        end
        apply(32'h0000007F, 32'h0, 1'b1);
        tests++;
        if ({ctrl, imm_o} !== {4'h0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0}) begin
            fails++; $display("FAIL bad_opcode got ctrl=%h imm=%h exp ctrl=%h imm=0",
                              ctrl, imm_o, {4'h0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1});
        end
    endtask

    task automatic test_stall_flush;
        apply(32'h002081B3, 32'h44, 1'b1);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apply(32'h402081B3, 32'h88, 1'b1);
            tests++;
            if ({ctrl, pc_o} !== {4'h0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h44}) begin
                fails++; $display("FAIL stall_hold[%0d] got ctrl=%h pc=%h exp ctrl=%h pc=44",
                                  i, ctrl, pc_o, {4'h0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0});
            end
        end
        flush_i = 1'b1;
        apply(32'h402081B3, 32'h88, 1'b1);
        tests++;
        if ({ctrl, imm_o, pc_o, rs1_addr_o, rs2_addr_o, rd_addr_o} !== '0) begin
            fails++; $display("FAIL flush_over_stall got ctrl=%h pc=%h exp all zero", ctrl, pc_o);
        end
        flush_i = 1'b0;
        stall_i = 1'b0;
        apply(32'h402081B3, 32'h88, 1'b1);
        apply(32'h402081B3, 32'h88, 1'b0);
        tests++;
        if ({ctrl, imm_o, pc_o, rs1_addr_o, rs2_addr_o, rd_addr_o} !== '0) begin
            fails++; $display("FAIL invalid_bubble got ctrl=%h pc=%h exp all zero", ctrl, pc_o);
        end
    endtask

    task automatic test_reset_mid_stall;
        apply(32'h002081B3, 32'h50, 1'b1);
        stall_i = 1'b1;
        #2 rst_i = 1'b1;
        #1;
        tests++;
        if ({ctrl, imm_o, pc_o, rs1_addr_o, rs2_addr_o, rd_addr_o} !== '0) begin
            fails++; $display("FAIL async_reset got ctrl=%h pc=%h exp all zero", ctrl, pc_o);
        end
        rst_i = 1'b0;
        apply(32'h002081B3, 32'h50, 1'b1);
        tests++;
        if ({ctrl, pc_o} !== '0) begin
            fails++; $display("FAIL stall_after_reset got ctrl=%h pc=%h exp all zero", ctrl, pc_o);
        end
        stall_i = 1'b0;
        apply(32'h002081B3, 32'h50, 1'b1);
        tests++;
        if ({ctrl, pc_o} !== {4'h0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h50}) begin
            fails++; $display("FAIL reload_after_reset got ctrl=%h pc=%h exp ctrl=%h pc=50",
                              ctrl, pc_o, {4'h0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0});
        end
    endtask

    initial begin
        rst_i   = 1'b1;
        instr_i = 32'h002081B3;
        pc_i    = 32'h0;
        valid_i = 1'b1;
        stall_i = 1'b0;
        flush_i = 1'b0;
        #2;
        test_reset();
        test_op();
        test_op_imm();
        test_upper_mem_ctrl();
        test_stall_flush();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_decoder.md
Name: alu_ctrl_decoder

Overview:
- ID-stage producer of the EX-stage ALU control interface (alu_op, operand selects, immediate).
- Decodes RV32I instruction words into the ALU's 4-bit op code, operand-mux selects and the immediate.
- Registers the results into the ID/EX pipeline register, with stall, flush and bubble handling.
- Sits between the IF/ID register and the EX stage; its alu_op_o drives the ALU op input directly.

Parameters:
- XLEN, 32, datapath width of PC and immediate.
- ILLEGAL_ALU_OP, 4'h0, alu_op_o value emitted for an illegal instruction.

Ports:
- clk_i  input  1  clock; all state on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- instr_i  input  32  instruction word from IF/ID.
- pc_i  input  XLEN  PC of instr_i.
- valid_i  input  1  instr_i/pc_i valid this cycle.
- stall_i  input  1  hold the ID/EX register contents.
- flush_i  input  1  replace the ID/EX contents with a bubble.
- alu_op_o  output  4  ALU op: 0 ADD, 1 SUB, 2 SLT, 3 SLTU, 4 XOR, 5 OR, 6 AND, 7 SLL, 8 SRL, 9 SRA, A PASS_B.
- op_a_sel_o  output  2  0 rs1, 1 PC, 2 zero.
- op_b_sel_o  output  1  0 rs2, 1 imm.
- imm_o  output  XLEN  decoded immediate.
- rs1_addr_o, rs2_addr_o, rd_addr_o  output  5 each  register indices.
- rd_we_o  output  1  register write enable.
- pc_o  output  XLEN  registered PC.
- valid_o  output  1  ID/EX slot holds an instruction.
- illegal_o  output  1  decoded instruction is illegal.

Behaviour:
- Reset (async, rst_i=1): every output is 0 immediately and while held, i.e. ADD, rs1, rs2, bubble. First capture happens on the first rising edge after deassertion.
- Latency: 1 cycle. Decode is combinational from instr_i and is registered on the clk_i edge.
- Per-edge priority:
  - flush_i: bubble.
  - else stall_i: hold all outputs.
  - else valid_i=1: load decoded fields, valid_o=1.
  - else: bubble.
- Bubble: all outputs 0.
- flush_i wins over a simultaneous stall_i.
- Immediate formats: I, S, B, U, J, sign-extended to XLEN. For OP-IMM shifts, imm_o = zero-extended shamt (instr[24:20]).
- Decode table:
  - OP 0110011: funct3 000 gives ADD if funct7=0000000, SUB if 0100000. 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA by funct7, 110 OR, 111 AND. a=rs1, b=rs2. funct7 other than 0000000 (or 0100000 on 000/101) is illegal.
  - OP-IMM 0010011: same mapping, no SUB. b=imm_I. SLLI/SRLI require funct7=0000000, SRAI requires 0100000; otherwise illegal.
  - LUI 0110111: PASS_B, b=imm_U.
  - AUIPC 0010111: ADD, a=PC, b=imm_U.
  - LOAD 0000011, JALR 1100111: ADD, a=rs1, b=imm_I.
  - STORE 0100011: ADD, a=rs1, b=imm_S, rd_we=0.
  - BRANCH 1100011: ADD, a=PC, b=imm_B, rd_we=0.
  - JAL 1101111: ADD, a=PC, b=imm_J.
  - Any other opcode, or instr[1:0]!=11: illegal.
- Illegal instruction: valid_o=1, illegal_o=1, alu_op_o=ILLEGAL_ALU_OP, rd_we_o=0, selects 0, imm_o 0.
- rd_we_o is forced 0 when rd_addr_o=0.
- rs1_addr_o/rs2_addr_o are always the raw instr[19:15] and [24:20], even when unused. Hazard logic qualifies them.
- Reset asserted mid-stall: outputs clear immediately. Stall state is not retained.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), valid_i=1 -> next edge: alu_op_o=0, a_sel=0, b_sel=0, rd=3, rd_we=1, valid_o=1. SUB (0x402081B3) -> alu_op_o=1.
- SRAI x5,x6,3 (0x40335293) -> alu_op_o=9, b_sel=1, imm_o=0x00000003, rs1=6, rd=5. Same word with funct7=0000001 (0x02335293) -> illegal_o=1, rd_we_o=0.
- LUI x1,0x12345 (0x123450B7) -> alu_op_o=A, imm_o=0x12345000. AUIPC x1,0x12345 (0x12345097), pc_i=0x100 -> alu_op_o=0, a_sel=1, pc_o=0x100.
- SW x2,-4(x1) (0xFE20AE23) -> alu_op_o=0, imm_o=0xFFFFFFFC, rd_we_o=0. ADDI x0,x0,1 -> rd_we_o=0.
- Load ADD, then stall_i=1 for 3 cycles with SUB on instr_i -> outputs stay ADD. Assert stall_i=1 and flush_i=1 together -> bubble next edge. valid_i=0 -> bubble.
- rst_i pulsed between edges while valid_o=1 -> all outputs 0 before the next edge. Opcode 0x7F -> illegal_o=1, valid_o=1, alu_op_o=0.
